servo_ramp: RTL and testbench
=============================

SERVO_RAMP -- requirements
Module: servo_ramp

Interface
REQ-001 Parameter TICK_CYCLES, default 1_000_000, clocks per ramp tick; equals one servo PWM period.
REQ-002 Parameter STEP, default 1, position units moved per tick while ramping; legal range 1..100.
REQ-003 Parameter HOLD_TICKS, default 50, ticks pwm_en stays high after target reached; 0 = hold forever.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-006 cmd_valid  in  1  target command present.
REQ-007 cmd_ready  out  1  block can accept a command this cycle.
REQ-008 cmd_pos  in  8  requested position, units matching downstream PWM data (25 = min pulse, 125 = max pulse).
REQ-009 pos_out  out  16  current ramped position; drives the PWM stage data input; upper 9 bits always 0.
REQ-010 pwm_en  out  1  drives the PWM stage enable.
REQ-011 at_target  out  1  high when pos_out equals the latched target.

Function
REQ-012 Clamp cmd_pos into 25..125 before latching: below 25 -> 25; above 125 -> 125.
REQ-013 FSM states IDLE, RAMP, HOLD; cmd_ready = 1 in IDLE and HOLD, 0 in RAMP (combinational from state).
REQ-014 Command accepted on a rising edge with cmd_valid & cmd_ready; clamped value latched into target on that edge.
REQ-015 On acceptance: clamped target != pos_out -> RAMP; otherwise -> HOLD with hold counter cleared.
REQ-016 pwm_en = 1 in RAMP and HOLD, 0 in IDLE; registered, so pwm_en rises on the acceptance edge (1-cycle latency from cmd_valid sampled).
REQ-017 Tick counter free-runs 0..TICK_CYCLES-1 from reset, independent of state; tick asserted for one cycle when count = TICK_CYCLES-1, then wraps to 0.
REQ-018 pos_out changes only on tick cycles while in RAMP; never on acceptance.
REQ-019 RAMP tick: |target - pos_out| <= STEP -> pos_out = target, go HOLD, clear hold counter; else pos_out moves STEP toward target.
REQ-020 Ramp arithmetic uses at least 9-bit signed difference; pos_out never overshoots target and never leaves 25..125.
REQ-021 HOLD tick: HOLD_TICKS != 0 and hold counter = HOLD_TICKS-1 -> IDLE; else increment hold counter.
REQ-022 IDLE and HOLD: pos_out frozen; command in HOLD restarts per REQ-015 (re-target allowed without dropping pwm_en).
REQ-023 Acceptance and tick on the same edge: acceptance wins; no position step that edge; hold counter cleared.
REQ-024 cmd_valid while in RAMP is ignored (not latched); issuer must hold it until cmd_ready.
REQ-025 at_target combinational compare of pos_out and target.

Reset
REQ-026 rst_n low, any state, asynchronously: state IDLE, pos_out = 75, target = 75, tick counter 0, hold counter 0, pwm_en 0; hence cmd_ready 1, at_target 1.
REQ-027 Reset mid-ramp discards target; no partial command survives deassertion.
REQ-028 First tick after reset release occurs TICK_CYCLES cycles after the first active edge.

Structure
REQ-029 Shared package servo_pkg holds POS_MIN = 25, POS_MAX = 125, POS_CENTER = 75 and the FSM state enumeration; the PWM stage uses the same constants.
REQ-030 One sub-module servo_tick (parameter TICK_CYCLES, ports clk, rst_n, tick) implements REQ-017; everything else in servo_ramp.

Verification (TICK_CYCLES = 10, STEP = 5, HOLD_TICKS = 3)
REQ-031 Reset, then cmd_pos = 100 for one cycle -> cmd_ready 0 next cycle, pwm_en 1, pos_out 75->80->...->100 one step per tick over 5 ticks, then HOLD, at_target 1, pwm_en 0 after 3 further ticks.
REQ-032 cmd_pos = 200 and cmd_pos = 0 -> targets 125 and 25; pos_out never outside 25..125.
REQ-033 Current pos 100, cmd_pos = 98 (difference 2 < STEP) -> single tick lands on 98, no overshoot.
REQ-034 cmd_valid held high during RAMP with new value 40 -> ignored until HOLD, then accepted; pwm_en stays 1 throughout.
REQ-035 Acceptance coincident with tick -> pos_out unchanged that edge; stepping starts next tick.
REQ-036 rst_n pulsed low mid-ramp between clock edges -> pwm_en 0 and pos_out 75 immediately, before the next clk edge.

Source files
------------

// File: rtl/servo_pkg.sv
// Constants and state encoding shared by the servo ramp and the downstream PWM stage.
// Position units match the PWM data word: 25 = minimum pulse, 125 = maximum pulse.
package servo_pkg;

    localparam logic [6:0] POS_MIN    = 7'd25;
    localparam logic [6:0] POS_MAX    = 7'd125;
    localparam logic [6:0] POS_CENTER = 7'd75;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2
    } servo_state_e;

    // Saturate a raw 8-bit command into the legal pulse range.
    function automatic logic [6:0] clamp_pos(input logic [7:0] raw);
        logic [6:0] res;
        if (raw < {1'b0, POS_MIN}) begin
            res = POS_MIN;
        end else if (raw > {1'b0, POS_MAX}) begin
            res = POS_MAX;
        end else begin
            res = raw[6:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/servo_tick.sv
// Free-running divider producing a one-cycle tick once per servo PWM period.
// The count is independent of the ramp state so ticks stay aligned to the PWM frame.
module servo_tick #(
    parameter int TICK_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int            CW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt_r;
    logic          last_s;

    assign last_s = (cnt_r == LAST);
    assign tick   = last_s;

    // Period counter: wraps to zero on the tick cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (last_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

endmodule

// File: rtl/servo_ramp.sv
// Slew-limited servo position generator: latches a clamped target and walks pos_out
// toward it by STEP per PWM period, then holds the PWM enabled for HOLD_TICKS periods.
module servo_ramp
    import servo_pkg::*;
#(
    parameter int TICK_CYCLES = 1_000_000,
    parameter int STEP        = 1,
    parameter int HOLD_TICKS  = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_pos,
    output logic [15:0] pos_out,
    output logic        pwm_en,
    output logic        at_target
);

    localparam logic [6:0]  STEP_P       = 7'(STEP);
    localparam logic [8:0]  STEP_W       = 9'(STEP);
    localparam logic [31:0] HOLD_LAST    = 32'(HOLD_TICKS - 1);
    localparam logic        HOLD_FOREVER = (HOLD_TICKS == 0);

    servo_state_e       state_r, state_s;
    logic [6:0]         pos_r, pos_s;
    logic [6:0]         target_r, target_s;
    logic [31:0]        hold_r, hold_s;
    logic               pwm_en_r;
    logic               tick_s;
    logic               accept_s;
    logic [6:0]         clamp_s;
    logic signed [8:0]  diff_s;
    logic [8:0]         mag_s;

    servo_tick #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick_s)
    );

    assign cmd_ready = (state_r != RAMP);
    assign accept_s  = cmd_valid & cmd_ready;
    assign clamp_s   = clamp_pos(cmd_pos);
    assign at_target = (pos_r == target_r);
    assign pos_out   = {9'd0, pos_r};
    assign pwm_en    = pwm_en_r;

    // Signed distance to target; wide enough that 125-25 never wraps.
    assign diff_s = $signed({2'b00, target_r}) - $signed({2'b00, pos_r});
    assign mag_s  = diff_s[8] ? (9'd0 - diff_s) : diff_s;

    // Next-state logic; an accepted command takes priority over a coincident tick.
    always_comb begin
        state_s  = state_r;
        pos_s    = pos_r;
        target_s = target_r;
        hold_s   = hold_r;
        if (accept_s) begin
            target_s = clamp_s;
            hold_s   = 32'd0;
            if (clamp_s != pos_r) begin
                state_s = RAMP;
            end else begin
                state_s = HOLD;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                RAMP: begin
                    if (!tick_s) begin
                        state_s = RAMP;
                    end else if (mag_s <= STEP_W) begin
                        pos_s   = target_r;
                        state_s = HOLD;
                        hold_s  = 32'd0;
                    end else if (diff_s[8]) begin
                        pos_s = pos_r - STEP_P;
                    end else begin
                        pos_s = pos_r + STEP_P;
                    end
                end
                HOLD: begin
                    if (!tick_s || HOLD_FOREVER) begin
                        hold_s = hold_r;
                    end else if (hold_r == HOLD_LAST) begin
                        state_s = IDLE;
                        hold_s  = 32'd0;
                    end else begin
                        hold_s = hold_r + 32'd1;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State, position and enable registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            pos_r    <= POS_CENTER;
            target_r <= POS_CENTER;
            hold_r   <= 32'd0;
            pwm_en_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            pos_r    <= pos_s;
            target_r <= target_s;
            hold_r   <= hold_s;
            pwm_en_r <= (state_s != IDLE);
        end
    end

endmodule

// File: tb/tb_servo_ramp.sv
// Scoreboard bench for servo_ramp with TICK_CYCLES=10, STEP=5, HOLD_TICKS=3.
// Expected positions are queued when a command is issued and popped on each pos_out change.
module tb_servo_ramp;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_pos;
    logic [15:0] pos_out;
    logic        pwm_en;
    logic        at_target;

    int checks = 0;
    int errors = 0;
    int edge_cnt;
    int model_pos = 75;
    int exp_q[$];
    logic [15:0] prev_pos;
    logic pwm_low_seen = 1'b0;

    servo_ramp #(
        .TICK_CYCLES(10),
        .STEP       (5),
        .HOLD_TICKS (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_pos  (cmd_pos),
        .pos_out  (pos_out),
        .pwm_en   (pwm_en),
        .at_target(at_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since reset release; ticks land on multiples of 10.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Scoreboard: every position change must match the next queued value.
    always @(negedge clk) begin
        if (rst_n && pos_out !== prev_pos) begin
            if (exp_q.size() == 0) check("sb_unexpected_step", 32'(exp_q.size()), 32'd1);
            else                   check("sb_pos", 32'(pos_out), 32'(exp_q.pop_front()));
            check("range", 32'(pos_out >= 16'd25 && pos_out <= 16'd125), 32'd1);
        end
        prev_pos <= pos_out;
    end

    task automatic push_ramp(input int raw);
        int tgt;
        tgt = (raw < 25) ? 25 : ((raw > 125) ? 125 : raw);
        while (model_pos != tgt) begin
            if (tgt > model_pos) model_pos = (tgt - model_pos <= 5) ? tgt : model_pos + 5;
            else                 model_pos = (model_pos - tgt <= 5) ? tgt : model_pos - 5;
            exp_q.push_back(model_pos);
        end
    endtask

    task automatic wait_edge(input int n);
        for (int i = 0; i < 2000 && edge_cnt < n; i++) @(negedge clk);
        check("edge_reach", 32'(edge_cnt >= n), 32'd1);
    endtask

    task automatic issue(input logic [7:0] p);
        for (int i = 0; i < 500 && !cmd_ready; i++) @(negedge clk);
        check("ready_wait", 32'(cmd_ready), 32'd1);
        push_ramp(int'(p));
        cmd_pos   = p;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_target();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!pwm_en) pwm_low_seen = 1'b1;
            if (at_target && pos_out == 16'(model_pos)) break;
        end
        #1;
        check("reach_target", 32'(pos_out), 32'(model_pos));
        check("sb_drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int e0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_pos   = 8'd0;
        #22;
        check("rst_pos", 32'(pos_out), 32'd75);
        check("rst_pwm", 32'(pwm_en), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_at_target", 32'(at_target), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic ramp 75 -> 100 then hold expiry
        wait_edge(1);
        issue(8'd100);
        check("ramp_ready_low", 32'(cmd_ready), 32'd0);
        check("ramp_pwm_on", 32'(pwm_en), 32'd1);
        check("ramp_not_at", 32'(at_target), 32'd0);
        wait_edge(9);
        check("pre_tick_pos", 32'(pos_out), 32'd75);
        wait_edge(10);
        check("first_step", 32'(pos_out), 32'd80);
        wait_target();
        check("hold_at_target", 32'(at_target), 32'd1);
        check("hold_pwm_on", 32'(pwm_en), 32'd1);
        check("hold_edge", 32'(edge_cnt), 32'd50);
        wait_edge(79);
        check("hold_last_pwm", 32'(pwm_en), 32'd1);
        wait_edge(80);
        check("idle_pwm_off", 32'(pwm_en), 32'd0);
        check("idle_ready", 32'(cmd_ready), 32'd1);

        // Clamping at both ends, then a sub-STEP move
        issue(8'd200);
        wait_target();
        check("clamp_hi", 32'(pos_out), 32'd125);
        issue(8'd0);
        wait_target();
        check("clamp_lo", 32'(pos_out), 32'd25);
        issue(8'd100);
        wait_target();
        issue(8'd98);
        e0 = edge_cnt;
        wait_target();
        check("small_step_one_tick", 32'(edge_cnt - e0 <= 10), 32'd1);

        // Command held through RAMP: ignored until HOLD, enable never drops
        pwm_low_seen = 1'b0;
        push_ramp(60);
        push_ramp(40);
        cmd_pos   = 8'd60;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_pos = 8'd40;
        check("busy_ready_low", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < 200; i++) begin
            if (!pwm_en) pwm_low_seen = 1'b1;
            if (pos_out == 16'd60 && cmd_ready) break;
            @(negedge clk);
        end
        check("first_target_60", 32'(pos_out), 32'd60);
        @(negedge clk);
        check("second_accept", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        wait_target();
        check("retarget_pwm_kept", 32'(pwm_low_seen), 32'd0);

        // Acceptance on a tick edge: no step that edge
        for (int i = 0; i < 20; i++) begin
            if (edge_cnt % 10 == 9) break;
            @(negedge clk);
        end
        issue(8'd50);
        check("coinc_tick_edge", 32'(edge_cnt % 10), 32'd0);
        check("coinc_no_step", 32'(pos_out), 32'd40);
        e0 = edge_cnt;
        wait_edge(e0 + 9);
        check("coinc_wait", 32'(pos_out), 32'd40);
        wait_edge(e0 + 10);
        check("coinc_next_tick", 32'(pos_out), 32'd45);
        wait_target();

        // Asynchronous reset mid-ramp
        issue(8'd120);
        e0 = edge_cnt;
        wait_edge(e0 + 25);
        check("midramp_moving", 32'(pos_out > 16'd50 && pos_out < 16'd120), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_pwm", 32'(pwm_en), 32'd0);
        check("async_pos", 32'(pos_out), 32'd75);
        check("async_ready", 32'(cmd_ready), 32'd1);
        exp_q.delete();
        model_pos = 75;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_edge(25);
        check("post_rst_pos", 32'(pos_out), 32'd75);
        check("post_rst_pwm", 32'(pwm_en), 32'd0);
        check("post_rst_at", 32'(at_target), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
